dsp_loader: RTL and testbench

DSP_LOADER -- requirements
Module: dsp_loader

---
 rtl/dsp_pkg.sv | 18 +
 rtl/dsp_run_timer.sv | 31 +++
 rtl/dsp_loader.sv | 135 +++++++++++++
 tb/tb_dsp_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP coefficient loader: FSM encoding and register-file geometry.
package dsp_pkg;

  localparam int unsigned DSP_ADDR_W   = 3;
  localparam int unsigned DSP_NUM_REGS = 8;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StKick = 2'd1,
    StRun  = 2'd2
  } dsp_state_e;

  // True when the pointer addresses the final DSP register.
  function automatic logic is_last_reg(input logic [DSP_ADDR_W-1:0] ptr);
    return ptr == DSP_ADDR_W'(DSP_NUM_REGS - 1);
  endfunction

endpackage

// File: rtl/dsp_run_timer.sv
// Loadable down-counter that times the RUN window and flags its final cycle.
module dsp_run_timer
  import dsp_pkg::*;
#(
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expire
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rstn || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - Width'(1);
    end
  end

  // Asserted during the last cycle of the window so the owner leaves RUN on that edge.
  assign o_expire = i_en && (r_count == Width'(1));

endmodule

// File: rtl/dsp_loader.sv
// Streams up to eight coefficient beats into DSP registers, then kicks and times a DSP run.
module dsp_loader
  import dsp_pkg::*;
#(
  parameter logic        rst_val    = 1'b0,
  parameter int unsigned bus_width  = 24,
  parameter int unsigned run_cycles = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [bus_width-1:0]  s_data,
  input  logic                  s_last,
  input  logic [7:0]            cfg_param,
  input  logic                  abort,
  output logic                  en,
  output logic                  start,
  output logic [7:0]            param,
  output logic [DSP_ADDR_W-1:0] addr,
  output logic [bus_width-1:0]  din,
  output logic                  we,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned TIMER_W = $clog2(run_cycles + 1);

  dsp_state_e            r_state;
  dsp_state_e            w_state_next;
  logic [DSP_ADDR_W-1:0] r_wr_ptr;
  logic                  r_we;
  logic                  r_start;
  logic                  r_busy;
  logic                  r_done;
  logic [DSP_ADDR_W-1:0] r_addr;
  logic [bus_width-1:0]  r_din;
  logic [7:0]            r_param;
  logic                  w_accept;
  logic                  w_burst_end;
  logic                  w_expire;

  assign s_ready     = (r_state == StLoad);
  assign w_accept    = s_valid && s_ready;
  assign w_burst_end = w_accept && (s_last || is_last_reg(r_wr_ptr));

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = StLoad;
    end else begin
      unique case (r_state)
        StLoad:  if (w_burst_end) w_state_next = StKick;
        StKick:  w_state_next = StRun;
        StRun:   if (w_expire) w_state_next = StLoad;
        default: w_state_next = StLoad;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= StLoad;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_we     <= 1'b0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_addr   <= '0;
      r_din    <= {bus_width{rst_val}};
      r_param  <= 8'h00;
    end else begin
      r_we    <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      if (abort) begin
        // A beat arriving with abort is dropped; addr/din keep their last values.
        r_wr_ptr <= '0;
        r_busy   <= 1'b0;
      end else begin
        unique case (r_state)
          StLoad: begin
            if (w_accept) begin
              r_we     <= 1'b1;
              r_addr   <= r_wr_ptr;
              r_din    <= s_data;
              r_busy   <= 1'b1;
              r_wr_ptr <= w_burst_end ? '0 : r_wr_ptr + DSP_ADDR_W'(1);
            end
          end
          StKick: begin
            r_start <= 1'b1;
            r_param <= cfg_param;
          end
          StRun: begin
            if (w_expire) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  dsp_run_timer #(
    .Width(TIMER_W)
  ) u_run_timer (
    .clk       (clk),
    .rstn      (rstn),
    .i_clear   (abort),
    .i_load    ((r_state == StKick) && !abort),
    .i_load_val(TIMER_W'(run_cycles)),
    .i_en      (r_state == StRun),
    .o_expire  (w_expire)
  );

  assign we    = r_we;
  assign start = r_start;
  assign busy  = r_busy;
  assign en    = r_busy;
  assign done  = r_done;
  assign addr  = r_addr;
  assign din   = r_din;
  assign param = r_param;

endmodule

// File: tb/tb_dsp_loader.sv
// Scoreboard bench for dsp_loader: stimulus queues expected writes/starts/dones, a monitor pops them.
module tb_dsp_loader;

  localparam int unsigned BW   = 16;
  localparam int unsigned NRUN = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          abort = 1'b0;
  logic [BW-1:0] s_data = '0;
  logic [7:0]    cfg_param = 8'h00;
  logic          s_ready, en, start, we, busy, done;
  logic [7:0]    param;
  logic [2:0]    addr;
  logic [BW-1:0] din;

  dsp_loader #(
    .rst_val   (1'b1),
    .bus_width (BW),
    .run_cycles(NRUN)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .cfg_param(cfg_param),
    .abort    (abort),
    .en       (en),
    .start    (start),
    .param    (param),
    .addr     (addr),
    .din      (din),
    .we       (we),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [2:0] addr; logic [BW-1:0] din;} wr_t;
  typedef struct {int cyc; logic [7:0] p;} st_t;
  wr_t wq[$];
  st_t sq[$];
  int  dq[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got pulse expected none (cycle %0d)", nm, cyc);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (we) begin
        if (wq.size() == 0) unexpected("we");
        else begin
          wr_t e = wq.pop_front();
          chk("we_cycle", cyc, e.cyc);
          chk("we_addr", 32'(addr), 32'(e.addr));
          chk("we_din", 32'(din), 32'(e.din));
        end
      end
      if (start) begin
        if (sq.size() == 0) unexpected("start");
        else begin
          st_t s = sq.pop_front();
          chk("start_cycle", cyc, s.cyc);
          chk("start_param", 32'(param), 32'(s.p));
          chk("start_en", 32'(en), 32'd1);
        end
      end
      if (done) begin
        if (dq.size() == 0) unexpected("done");
        else begin
          int d = dq.pop_front();
          chk("done_cycle", cyc, d);
          chk("done_busy", 32'(busy), 32'd0);
          chk("done_ready", 32'(s_ready), 32'd1);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; the beat is accepted on the next edge.
  task automatic beat(input logic [BW-1:0] d, input logic l, input logic [2:0] ea);
    wr_t e;
    e.cyc = cyc + 1; e.addr = ea; e.din = d;
    wq.push_back(e);
    s_valid = 1'b1; s_data = d; s_last = l;
    idle(1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Called #1 after the edge that accepted the final beat.
  task automatic exp_start(input logic [7:0] p);
    st_t s;
    s.cyc = cyc + 1; s.p = p;
    sq.push_back(s);
  endtask

  task automatic exp_kick(input logic [7:0] p);
    exp_start(p);
    dq.push_back(cyc + 1 + NRUN);
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_we"}, 32'(we), 32'd0);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_en"}, 32'(en), 32'd0);
    chk({tag, "_ready"}, 32'(s_ready), 32'd1);
  endtask

  task automatic stimulus();
    // Reset state
    idle(2);
    chk_idle_state("rst");
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_param", 32'(param), 32'h00);
    chk("rst_din", 32'(din), 32'hFFFF);
    rstn = 1'b1;
    idle(1);

    // Three-beat burst with s_last on the third
    cfg_param = 8'h42;
    chk("t1_busy_pre", 32'(busy), 32'd0);
    beat(16'h0001, 1'b0, 3'd0);
    chk("t1_busy_first", 32'(busy), 32'd1);
    beat(16'h0002, 1'b0, 3'd1);
    beat(16'h0003, 1'b1, 3'd2);
    exp_kick(8'h42);
    idle(2);
    cfg_param = 8'h99;
    idle(NRUN + 2);
    chk("t1_param_hold", 32'(param), 32'h42);
    chk_idle_state("t1_end");

    // Eight beats, no s_last: auto-kick after addr 7, then restart at addr 0
    cfg_param = 8'h11;
    for (int i = 0; i < 8; i++) beat(16'h0100 + BW'(i), 1'b0, 3'(i));
    exp_kick(8'h11);
    idle(NRUN + 3);
    beat(16'h0200, 1'b1, 3'd0);
    exp_kick(8'h11);
    idle(NRUN + 3);

    // Abort with a beat (dropped, pointer cleared), then abort two cycles into RUN
    cfg_param = 8'h33;
    beat(16'h00A1, 1'b0, 3'd0);
    s_valid = 1'b1; s_data = 16'h00A2; abort = 1'b1;
    idle(1);
    s_valid = 1'b0; abort = 1'b0;
    chk("t3_busy_drop", 32'(busy), 32'd0);
    chk("t3_en_drop", 32'(en), 32'd0);
    chk("t3_we_drop", 32'(we), 32'd0);
    beat(16'h00A3, 1'b1, 3'd0);
    exp_start(8'h33);
    idle(2);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    chk_idle_state("t3_abort_run");
    idle(NRUN + 3);

    // s_valid held through KICK/RUN: next beat only after done, at addr 0
    cfg_param = 8'h44;
    begin
      wr_t e;
      e.cyc = cyc + 1; e.addr = 3'd0; e.din = 16'h00B1;
      wq.push_back(e);
      s_valid = 1'b1; s_data = 16'h00B1; s_last = 1'b1;
      idle(1);
      exp_kick(8'h44);
      s_data = 16'h00B2;
      e.cyc = cyc + NRUN + 2; e.addr = 3'd0; e.din = 16'h00B2;
      wq.push_back(e);
      idle(NRUN + 2);
      s_valid = 1'b0; s_last = 1'b0;
      exp_kick(8'h44);
    end
    idle(NRUN + 3);

    // One-cycle reset mid-RUN: no done, din back to fill value, restart at addr 0
    cfg_param = 8'h55;
    beat(16'h00C1, 1'b1, 3'd0);
    exp_start(8'h55);
    idle(2);
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    chk_idle_state("t5_rst");
    chk("t5_rst_din", 32'(din), 32'hFFFF);
    chk("t5_rst_addr", 32'(addr), 32'd0);
    chk("t5_rst_param", 32'(param), 32'h00);
    idle(NRUN + 2);
    beat(16'h00C2, 1'b1, 3'd0);
    exp_kick(8'h55);
    idle(NRUN + 3);

    chk("left_writes", 32'(wq.size()), 32'd0);
    chk("left_starts", 32'(sq.size()), 32'd0);
    chk("left_dones", 32'(dq.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
